// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared types, constants and sample packing for the FFT frame sequencer
package fft_seq_pkg;

  typedef enum logic [1:0] {
    CONFIG      = 2'd0,
    IDLE        = 2'd1,
    STREAM      = 2'd2,
    WAIT_RESULT = 2'd3
  } seq_state_t;

  localparam logic [15:0] CFG_FWD  = 16'h0001;
  localparam int          SAMPLE_W = 8;
  localparam int          CFG_W    = 16;
  localparam int          TDATA_W  = 32;
  localparam int          CNT_W    = 16;
  localparam int          IMAG_W   = 16;
  localparam int          PAD_W    = 8;

  // Complex word: imaginary zero, real part is the sample left-justified in 16 bits.
  function automatic logic [TDATA_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] s);
    return {{IMAG_W{1'b0}}, s, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sample_hold.sv
// rtl/sample_hold.sv - one-entry skid register with capture port and drop strobe
module sample_hold #(
  parameter int W = 9
) (
  input  logic         clk_m,
  input  logic         resetn,
  input  logic         cap_valid,
  input  logic [W-1:0] cap_data,
  output logic         cap_accept,
  output logic         drop,
  output logic         tvalid,
  output logic [W-1:0] tdata,
  input  logic         tready
);

  logic xfer;

  // A capture is accepted when empty or when the held entry leaves this same cycle.
  assign xfer       = tvalid & tready;
  assign cap_accept = cap_valid & (~tvalid | xfer);
  assign drop       = cap_valid & tvalid & ~xfer;

  always_ff @(posedge clk_m) begin
    if (!resetn) begin
      tvalid <= 1'b0;
      tdata  <= '0;
    end else if (cap_accept) begin
      tvalid <= 1'b1;
      tdata  <= cap_data;
    end else if (xfer) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - configures an FFT core then frames strobed samples into its input stream
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int               FRAME_LEN = 512,
  parameter logic [CFG_W-1:0] CFG_WORD  = CFG_FWD
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [CFG_W-1:0]    cfg_tdata_out,
  output logic                cfg_tvalid_out,
  input  logic                cfg_tready_in,
  output logic [TDATA_W-1:0]  s_tdata_out,
  output logic                s_tvalid_out,
  output logic                s_tlast_out,
  input  logic                s_tready_in,
  input  logic                m_tvalid_in,
  input  logic                m_tlast_in,
  input  logic                m_tready_in,
  output logic                busy_out,
  output logic [CNT_W-1:0]    frame_count_out,
  output logic [CNT_W-1:0]    drop_count_out,
  output logic                overrun_out
);

  localparam int                IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  seq_state_t          state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic                frame_done;
  logic                cap_valid, hold_accept, hold_drop;
  logic [SAMPLE_W:0]   hold_data;
  logic                last_xfer, result_done;

  assign last_xfer   = s_tvalid_out & s_tready_in & s_tlast_out;
  assign result_done = m_tvalid_in & m_tready_in & m_tlast_in;

  always_comb begin
    state_nxt = state;
    cap_valid = 1'b0;
    case (state)
      CONFIG:      if (cfg_tready_in) state_nxt = IDLE;
      IDLE: begin
        if (sample_valid_in && enable_in) begin
          cap_valid = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        // Once the final index is captured, later samples belong to no frame.
        cap_valid = sample_valid_in & ~frame_done;
        if (last_xfer) state_nxt = WAIT_RESULT;
      end
      WAIT_RESULT: if (result_done) state_nxt = IDLE;
      default:     state_nxt = CONFIG;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= CONFIG;
      idx             <= '0;
      frame_done      <= 1'b0;
      frame_count_out <= '0;
      drop_count_out  <= '0;
      overrun_out     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_accept) begin
        idx <= idx + 1'b1;
        if (idx == LAST_IDX) frame_done <= 1'b1;
      end
      if (last_xfer) frame_done <= 1'b0;
      if (hold_drop) begin
        overrun_out <= 1'b1;
        if (drop_count_out != {CNT_W{1'b1}}) drop_count_out <= drop_count_out + 1'b1;
      end
      if (state == WAIT_RESULT && result_done) frame_count_out <= frame_count_out + 1'b1;
    end
  end

  sample_hold #(.W(SAMPLE_W + 1)) u_hold (
    .clk_m      (clk_in),
    .resetn     (rst_in),
    .cap_valid  (cap_valid),
    .cap_data   ({idx == LAST_IDX, sample_in}),
    .cap_accept (hold_accept),
    .drop       (hold_drop),
    .tvalid     (s_tvalid_out),
    .tdata      (hold_data),
    .tready     (s_tready_in)
  );

  assign cfg_tdata_out  = CFG_WORD;
  assign cfg_tvalid_out = (state == CONFIG);
  assign busy_out       = (state != IDLE);
  assign s_tdata_out    = pack_sample(hold_data[SAMPLE_W-1:0]);
  assign s_tlast_out    = s_tvalid_out & hold_data[SAMPLE_W];

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in, enable_in, sample_valid_in;
  logic [7:0]  sample_in;
  logic [15:0] cfg_tdata_out;
  logic        cfg_tvalid_out, cfg_tready_in;
  logic [31:0] s_tdata_out;
  logic        s_tvalid_out, s_tlast_out, s_tready_in;
  logic        m_tvalid_in, m_tlast_in, m_tready_in;
  logic        busy_out, overrun_out;
  logic [15:0] frame_count_out, drop_count_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sv;
    logic [7:0]  smp;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [15:0] edrop;
    logic        eov;
  } vec_t;

  vec_t vecs [9];

  always #5 clk_in = ~clk_in;

  fft_frame_sequencer #(.FRAME_LEN(512), .CFG_WORD(16'h0001)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .cfg_tdata_out   (cfg_tdata_out),
    .cfg_tvalid_out  (cfg_tvalid_out),
    .cfg_tready_in   (cfg_tready_in),
    .s_tdata_out     (s_tdata_out),
    .s_tvalid_out    (s_tvalid_out),
    .s_tlast_out     (s_tlast_out),
    .s_tready_in     (s_tready_in),
    .m_tvalid_in     (m_tvalid_in),
    .m_tlast_in      (m_tlast_in),
    .m_tready_in     (m_tready_in),
    .busy_out        (busy_out),
    .frame_count_out (frame_count_out),
    .drop_count_out  (drop_count_out),
    .overrun_out     (overrun_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Strobe nsamp copies of val every gap cycles, observing transfers before each edge.
  task automatic run_stream(input int nsamp, input int gap, input logic [7:0] val,
                            output int xfers, output int last_cnt, output int last_at,
                            output int bad_data);
    logic [31:0] want;
    want = {16'h0000, val, 8'h00};
    xfers = 0; last_cnt = 0; last_at = -1; bad_data = 0;
    for (int c = 0; c < nsamp * gap + 8; c++) begin
      if (s_tvalid_out && s_tready_in) begin
        xfers++;
        if (s_tdata_out !== want) bad_data++;
        if (s_tlast_out) begin
          last_cnt++;
          if (last_at < 0) last_at = xfers;
        end
      end
      sample_valid_in = (c % gap == 0) && (c < nsamp * gap);
      sample_in       = val;
      tick();
    end
    sample_valid_in = 1'b0;
  endtask

  initial begin
    int hi, xf, lc, la, bd, sawv;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 32'h0000_1100, 16'd0, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 32'h0000_1100, 16'd1, 1'b1};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 32'h0000_1100, 16'd2, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_1100, 16'd2, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 16'd2, 1'b1};
    vecs[5] = '{1'b1, 8'h44, 1'b1, 1'b1, 32'h0000_4400, 16'd2, 1'b1};
    vecs[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 32'h0000_8000, 16'd2, 1'b1};
    vecs[7] = '{1'b1, 8'h5A, 1'b0, 1'b1, 32'h0000_8000, 16'd3, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 16'd3, 1'b1};

    rst_in = 1'b0; enable_in = 1'b0; sample_in = 8'h00; sample_valid_in = 1'b0;
    cfg_tready_in = 1'b0; s_tready_in = 1'b0;
    m_tvalid_in = 1'b0; m_tlast_in = 1'b0; m_tready_in = 1'b0;
    repeat (3) tick();

    check("rst_cfg_tvalid", 32'(cfg_tvalid_out), 32'd1);
    check("rst_cfg_tdata", 32'(cfg_tdata_out), 32'h0001);
    check("rst_s_tvalid", 32'(s_tvalid_out), 32'd0);
    check("rst_s_tlast", 32'(s_tlast_out), 32'd0);
    check("rst_counts", {frame_count_out, drop_count_out}, 32'd0);
    check("rst_overrun", 32'(overrun_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd1);

    // Config handshake: ready low for 3 cycles, then high.
    rst_in = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (cfg_tvalid_out) hi++;
      if (i == 3) cfg_tready_in = 1'b1;
      tick();
    end
    check("cfg_high_cycles", 32'(hi), 32'd4);
    check("cfg_idle_busy", 32'(busy_out), 32'd0);

    // Full frame of 8'h7F at one strobe per 32 cycles.
    enable_in = 1'b1; s_tready_in = 1'b1;
    run_stream(512, 32, 8'h7F, xf, lc, la, bd);
    check("f1_xfers", 32'(xf), 32'd512);
    check("f1_bad_data", 32'(bd), 32'd0);
    check("f1_last_cnt", 32'(lc), 32'd1);
    check("f1_last_at", 32'(la), 32'd512);
    check("f1_drops", 32'(drop_count_out), 32'd0);
    check("f1_wait_busy", 32'(busy_out), 32'd1);

    // Strobes during WAIT_RESULT are discarded.
    sawv = 0;
    for (int i = 0; i < 20; i++) begin
      sample_valid_in = (i % 2 == 0);
      sample_in = 8'h5C;
      tick();
      if (s_tvalid_out) sawv++;
    end
    sample_valid_in = 1'b0;
    check("wait_no_capture", 32'(sawv), 32'd0);
    check("wait_no_drops", 32'(drop_count_out), 32'd0);
    m_tvalid_in = 1'b1; m_tready_in = 1'b1; m_tlast_in = 1'b0;
    tick();
    check("wait_nolast_fc", 32'(frame_count_out), 32'd0);
    check("wait_nolast_busy", 32'(busy_out), 32'd1);
    m_tlast_in = 1'b1;
    tick();
    m_tvalid_in = 1'b0; m_tready_in = 1'b0; m_tlast_in = 1'b0;
    check("f1_frame_count", 32'(frame_count_out), 32'd1);
    check("f1_back_idle", 32'(busy_out), 32'd0);

    // Gated strobes in IDLE are neither captured nor counted.
    enable_in = 1'b0;
    sawv = 0;
    for (int i = 0; i < 10; i++) begin
      sample_valid_in = (i % 2 == 0);
      sample_in = 8'h66;
      tick();
      if (s_tvalid_out || busy_out) sawv++;
    end
    sample_valid_in = 1'b0;
    check("idle_gated", 32'(sawv), 32'd0);
    check("idle_gated_drops", 32'(drop_count_out), 32'd0);

    // Backpressure and coincident-transfer table.
    enable_in = 1'b1;
    for (int r = 0; r < 9; r++) begin
      sample_valid_in = vecs[r].sv;
      sample_in       = vecs[r].smp;
      s_tready_in     = vecs[r].rdy;
      tick();
      check($sformatf("vec%0d_tvalid", r), 32'(s_tvalid_out), 32'(vecs[r].ev));
      if (vecs[r].ev) check($sformatf("vec%0d_tdata", r), s_tdata_out, vecs[r].ed);
      check($sformatf("vec%0d_tlast", r), 32'(s_tlast_out), 32'd0);
      check($sformatf("vec%0d_drops", r), 32'(drop_count_out), 32'(vecs[r].edrop));
      check($sformatf("vec%0d_overrun", r), 32'(overrun_out), 32'(vecs[r].eov));
    end
    sample_valid_in = 1'b0;
    s_tready_in = 1'b1;

    // Three samples captured so far; enable falls but the frame still completes.
    enable_in = 1'b0;
    run_stream(509, 4, 8'h3C, xf, lc, la, bd);
    check("f2_xfers", 32'(xf), 32'd509);
    check("f2_bad_data", 32'(bd), 32'd0);
    check("f2_last_at", 32'(la), 32'd509);
    check("f2_last_cnt", 32'(lc), 32'd1);
    m_tvalid_in = 1'b1; m_tready_in = 1'b1; m_tlast_in = 1'b1;
    tick();
    m_tvalid_in = 1'b0; m_tready_in = 1'b0; m_tlast_in = 1'b0;
    check("f2_frame_count", 32'(frame_count_out), 32'd2);
    check("f2_drops_kept", 32'(drop_count_out), 32'd3);

    // Partial frame abandoned by reset at index 200.
    enable_in = 1'b1;
    run_stream(200, 4, 8'hA5, xf, lc, la, bd);
    check("f3_xfers", 32'(xf), 32'd200);
    check("f3_no_last", 32'(lc), 32'd0);
    s_tready_in = 1'b0;
    sample_valid_in = 1'b1; sample_in = 8'hA5;
    tick();
    sample_valid_in = 1'b0;
    check("f3_idx200_held", 32'(s_tvalid_out), 32'd1);
    check("f3_idx200_nolast", 32'(s_tlast_out), 32'd0);
    rst_in = 1'b0;
    tick();
    check("mid_rst_tvalid", 32'(s_tvalid_out), 32'd0);
    check("mid_rst_tlast", 32'(s_tlast_out), 32'd0);
    check("mid_rst_counts", {frame_count_out, drop_count_out}, 32'd0);
    check("mid_rst_overrun", 32'(overrun_out), 32'd0);
    check("mid_rst_config", 32'(cfg_tvalid_out), 32'd1);
    rst_in = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
